mcse_host_gpio_responder: RTL and testbench

Host/SoC-side RTL counterpart of the MCSE GPIO boot protocol. It watches mcse_top gpio_out and drives mcse_top gpio_in. It answers four requests: reset, bus wakeup, IP ID trigger and operation release. For each IP ID trigger it streams the framed IP ID block from an external IP ID ROM. It replaces the behavioural host model in system-level sims and is the synthesizable host agent for FPGA bring-up.

---
 rtl/mcse_host_pkg.sv | 28 ++
 rtl/mcse_req_ack.sv | 24 ++
 rtl/mcse_host_gpio_responder.sv | 182 ++++++++++++++++++
 tb/tb_mcse_host_gpio_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcse_host_pkg.sv
// Shared definitions for the host-side MCSE GPIO boot responder:
// GPIO bit map, frame marker defaults and the IP ID stream states.
package mcse_host_pkg;

    localparam int RST_REQ   = 0;
    localparam int RST_ACK   = 1;
    localparam int OPR_REQ   = 4;
    localparam int OPR_ACK   = 5;
    localparam int WAKE_REQ  = 6;
    localparam int WAKE_ACK  = 7;
    localparam int BLK_LSB   = 8;
    localparam int BLK_MSB   = 11;
    localparam int IPID_TRIG = 12;
    localparam int IPID_VLD  = 13;
    localparam int DATA_LSB  = 16;

    localparam logic [15:0] FRAME_HDR_DEF = 16'h7A7A;
    localparam logic [15:0] FRAME_TRL_DEF = 16'hB9B9;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        TRL,
        WAIT_LOW
    } ipid_state_t;

endpackage

// File: rtl/mcse_req_ack.sv
// Level request/ack responder: ack mirrors the request one cycle late,
// and rise flags the cycle in which a new request is first sampled.
module mcse_req_ack (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic ack,
    output logic rise
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack <= 1'b0;
        end else begin
            ack <= req;
        end
    end

    // ack holds the previous sample, so it doubles as the edge reference.
    assign rise = req & ~ack;

endmodule

// File: rtl/mcse_host_gpio_responder.sv
// Host/SoC-side agent of the MCSE GPIO boot protocol: answers reset, wakeup
// and op-release requests and streams framed IP ID blocks from an external ROM.
module mcse_host_gpio_responder
    import mcse_host_pkg::*;
#(
    parameter int          GPIO_N          = 32,
    parameter logic [15:0] FRAME_HDR       = FRAME_HDR_DEF,
    parameter logic [15:0] FRAME_TRL       = FRAME_TRL_DEF,
    parameter int          NUM_BLOCKS      = 16,
    parameter int          WORDS_PER_BLOCK = 16,
    parameter int          SOC_RST_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_N-1:0] gpio_out,
    output logic [GPIO_N-1:0] gpio_in,
    output logic [7:0]        ipid_addr,
    input  logic [15:0]       ipid_rdata,
    output logic              soc_rst_n,
    output logic              soc_run,
    output logic              ipid_done,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(SOC_RST_CYCLES + 1);

    logic rst_ack, rst_rise;
    logic opr_ack, opr_rise;
    logic wake_ack, wake_rise;

    mcse_req_ack u_rst_req (
        .clk (clk), .rst (rst), .req (gpio_out[RST_REQ]),
        .ack (rst_ack), .rise (rst_rise)
    );

    mcse_req_ack u_opr_req (
        .clk (clk), .rst (rst), .req (gpio_out[OPR_REQ]),
        .ack (opr_ack), .rise (opr_rise)
    );

    mcse_req_ack u_wake_req (
        .clk (clk), .rst (rst), .req (gpio_out[WAKE_REQ]),
        .ack (wake_ack), .rise (wake_rise)
    );

    logic [CNT_W-1:0] rst_cnt;

    // A fresh reset request restarts the SoC reset pulse and revokes run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rst_cnt   <= '0;
            soc_rst_n <= 1'b1;
            soc_run   <= 1'b0;
        end else if (rst_rise) begin
            rst_cnt   <= CNT_W'(SOC_RST_CYCLES - 1);
            soc_rst_n <= 1'b0;
            soc_run   <= 1'b0;
        end else begin
            if (rst_cnt != '0) rst_cnt <= rst_cnt - CNT_W'(1);
            else               soc_rst_n <= 1'b1;
            if (opr_rise) soc_run <= 1'b1;
        end
    end

    ipid_state_t state, state_n;
    logic [3:0]  blk, blk_n;
    logic [4:0]  word, word_n;
    logic        vld, vld_n;
    logic [15:0] data, data_n;
    logic        done_n, err_n;
    logic        trig;
    logic [3:0]  req_blk;

    assign trig    = gpio_out[IPID_TRIG];
    assign req_blk = gpio_out[BLK_MSB:BLK_LSB];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            blk       <= '0;
            word      <= '0;
            vld       <= 1'b0;
            data      <= '0;
            ipid_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            blk       <= blk_n;
            word      <= word_n;
            vld       <= vld_n;
            data      <= data_n;
            ipid_done <= done_n;
            frame_err <= err_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_n = state;
        blk_n   = blk;
        word_n  = word;
        vld_n   = vld;
        data_n  = data;
        done_n  = ipid_done;
        err_n   = frame_err;

        if (rst_rise) begin
            state_n = IDLE;
            blk_n   = '0;
            word_n  = '0;
            vld_n   = 1'b0;
            data_n  = '0;
            done_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        if (ipid_done) begin
                            err_n = 1'b1;
                        end else begin
                            // The local block counter wins over the index the chip asked for.
                            if (req_blk != blk) err_n = 1'b1;
                            state_n = HDR;
                            vld_n   = 1'b1;
                            data_n  = FRAME_HDR;
                            word_n  = '0;
                        end
                    end
                end
                HDR: begin
                    data_n  = ipid_rdata;
                    word_n  = 5'd1;
                    state_n = DATA;
                end
                DATA: begin
                    if (word == 5'(WORDS_PER_BLOCK)) begin
                        data_n  = FRAME_TRL;
                        word_n  = '0;
                        state_n = TRL;
                    end else begin
                        data_n = ipid_rdata;
                        word_n = word + 5'd1;
                    end
                end
                TRL: begin
                    vld_n   = 1'b0;
                    data_n  = '0;
                    state_n = WAIT_LOW;
                    if (blk == 4'(NUM_BLOCKS - 1)) done_n = 1'b1;
                    else                           blk_n  = blk + 4'd1;
                end
                WAIT_LOW: begin
                    if (!trig) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase

            if (!trig && (state == HDR || state == DATA || state == TRL)) err_n = 1'b1;

            if (wake_rise) begin
                blk_n  = '0;
                done_n = 1'b0;
            end
        end
    end

    assign ipid_addr = {blk, word[3:0]};

    always_comb begin
        gpio_in                     = '0;
        gpio_in[RST_ACK]            = rst_ack;
        gpio_in[OPR_ACK]            = opr_ack;
        gpio_in[WAKE_ACK]           = wake_ack;
        gpio_in[IPID_VLD]           = vld;
        gpio_in[DATA_LSB +: 16]     = data;
    end

    logic unused_gpio;
    assign unused_gpio = ^{gpio_out[GPIO_N-1:13], gpio_out[7], gpio_out[5], gpio_out[3:1]};

endmodule

// File: tb/tb_mcse_host_gpio_responder.sv
// Self-checking bench for mcse_host_gpio_responder: request/ack table plus
// scoreboarded IP ID streams against a bench-side ROM model.
module tb_mcse_host_gpio_responder;
    import mcse_host_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] gpio_out = '0;
    logic [31:0] gpio_in;
    logic [7:0]  ipid_addr;
    logic [15:0] ipid_rdata;
    logic        soc_rst_n, soc_run, ipid_done, frame_err;

    always #5 clk = ~clk;

    assign ipid_rdata = {8'h00, ipid_addr} ^ 16'h5A00;

    mcse_host_gpio_responder dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_out   (gpio_out),
        .gpio_in    (gpio_in),
        .ipid_addr  (ipid_addr),
        .ipid_rdata (ipid_rdata),
        .soc_rst_n  (soc_rst_n),
        .soc_run    (soc_run),
        .ipid_done  (ipid_done),
        .frame_err  (frame_err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    int          run_len  = 0;
    int          last_run = 0;

    typedef struct {
        logic [2:0]  req;      // {rst_req, opr_req, wake_req}
        logic [31:0] exp_ack;  // gpio_in masked to bits 1/5/7
        logic        exp_run;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid cycle must match the next expected word.
    always @(posedge clk) begin
        #1;
        if (gpio_in[IPID_VLD]) begin
            run_len++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got data %h with nothing expected", gpio_in[31:16]);
            end else begin
                mon_exp = exp_q.pop_front();
                check("stream_word", {16'h0, gpio_in[31:16]}, {16'h0, mon_exp});
            end
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst      = 1'b0;
        gpio_out = '0;
        exp_q.delete();
        repeat (2) step();
        rst      = 1'b1;
        last_run = 0;
        step();
    endtask

    task automatic pulse(input int b);
        gpio_out[b] = 1'b1;
        step();
        gpio_out[b] = 1'b0;
        step();
    endtask

    task automatic push_words(input int b, input int n_words);
        logic [7:0] a;
        exp_q.push_back(FRAME_HDR_DEF);
        for (int w = 0; w < n_words; w++) begin
            a = {4'(b), 4'(w)};
            exp_q.push_back({8'h00, a} ^ 16'h5A00);
        end
    endtask

    task automatic push_block(input int b);
        push_words(b, 16);
        exp_q.push_back(FRAME_TRL_DEF);
    endtask

    task automatic wait_frame(input string name);
        bit seen  = 1'b0;
        bit ended = 1'b0;
        for (int i = 0; i < 60 && !ended; i++) begin
            step();
            if (gpio_in[IPID_VLD]) seen = 1'b1;
            else if (seen)         ended = 1'b1;
        end
        #2;
        check({name, "_ended"}, 32'(ended), 32'd1);
        check({name, "_len"}, last_run, 32'd18);
    endtask

    task automatic run_block(input int b, input int idx);
        gpio_out[BLK_MSB:BLK_LSB] = 4'(idx);
        gpio_out[IPID_TRIG]       = 1'b1;
        push_block(b);
        wait_frame($sformatf("blk%0d", b));
        gpio_out[IPID_TRIG] = 1'b0;
        step();
        step();
    endtask

    initial begin
        int lows;
        int vcount;
        int cnt;
        bit aborted;

        vecs[0] = '{3'b000, 32'h00, 1'b0};
        vecs[1] = '{3'b010, 32'h20, 1'b1};
        vecs[2] = '{3'b011, 32'hA0, 1'b1};
        vecs[3] = '{3'b001, 32'h80, 1'b1};
        vecs[4] = '{3'b100, 32'h02, 1'b0};
        vecs[5] = '{3'b110, 32'h22, 1'b1};
        vecs[6] = '{3'b000, 32'h00, 1'b1};
        vecs[7] = '{3'b110, 32'h22, 1'b0};
        vecs[8] = '{3'b000, 32'h00, 1'b0};

        // Reset state
        do_reset();
        check("rst_gpio_in", gpio_in, 32'h0);
        check("rst_soc_rst_n", 32'(soc_rst_n), 32'd1);
        check("rst_soc_run", 32'(soc_run), 32'd0);
        check("rst_ipid_done", 32'(ipid_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_ipid_addr", 32'(ipid_addr), 32'd0);

        // Request/ack table
        for (int i = 0; i < 9; i++) begin
            gpio_out           = '0;
            gpio_out[RST_REQ]  = vecs[i].req[2];
            gpio_out[OPR_REQ]  = vecs[i].req[1];
            gpio_out[WAKE_REQ] = vecs[i].req[0];
            step();
            check($sformatf("vec%0d_ack", i), gpio_in & 32'h0000_00A2, vecs[i].exp_ack);
            check($sformatf("vec%0d_run", i), 32'(soc_run), 32'(vecs[i].exp_run));
        end

        // Reset request held 5 cycles
        do_reset();
        gpio_out[RST_REQ] = 1'b1;
        lows = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (!soc_rst_n) lows++;
            if (i == 1) check("rstreq_soc_rst_low", 32'(soc_rst_n), 32'd0);
            if (i <= 5) check("rstreq_ack_hold", 32'(gpio_in[RST_ACK]), 32'd1);
            if (i == 5) gpio_out[RST_REQ] = 1'b0;
            if (i == 6) check("rstreq_ack_drop", 32'(gpio_in[RST_ACK]), 32'd0);
        end
        check("rstreq_low_cycles", lows, 32'd8);

        // Op release, then revoked by a reset request
        do_reset();
        gpio_out[OPR_REQ] = 1'b1;
        step();
        check("opr_ack", 32'(gpio_in[OPR_ACK]), 32'd1);
        check("opr_run", 32'(soc_run), 32'd1);
        gpio_out[OPR_REQ] = 1'b0;
        step();
        check("opr_ack_drop", 32'(gpio_in[OPR_ACK]), 32'd0);
        repeat (3) step();
        check("opr_run_held", 32'(soc_run), 32'd1);
        gpio_out[RST_REQ] = 1'b1;
        step();
        check("opr_run_cleared", 32'(soc_run), 32'd0);
        gpio_out[RST_REQ] = 1'b0;
        repeat (10) step();
        check("opr_soc_rst_released", 32'(soc_rst_n), 32'd1);

        // Full IP ID flow: 16 blocks
        do_reset();
        pulse(WAKE_REQ);
        for (int b = 0; b < 16; b++) begin
            if (b == 15) check("flow_done_before_last", 32'(ipid_done), 32'd0);
            run_block(b, b);
        end
        check("flow_done", 32'(ipid_done), 32'd1);
        check("flow_err", 32'(frame_err), 32'd0);
        check("flow_queue_empty", exp_q.size(), 32'd0);

        // Held trigger yields one frame only
        do_reset();
        pulse(WAKE_REQ);
        gpio_out[BLK_MSB:BLK_LSB] = 4'd0;
        gpio_out[IPID_TRIG]       = 1'b1;
        push_block(0);
        wait_frame("held0");
        vcount = 0;
        repeat (40) begin
            step();
            if (gpio_in[IPID_VLD]) vcount++;
        end
        check("held_no_restart", vcount, 32'd0);
        check("held_err", 32'(frame_err), 32'd0);
        gpio_out[IPID_TRIG] = 1'b0;
        step();
        step();
        run_block(1, 1);

        // Trigger dropped mid-frame: frame completes, error flagged
        do_reset();
        pulse(WAKE_REQ);
        gpio_out[BLK_MSB:BLK_LSB] = 4'd0;
        gpio_out[IPID_TRIG]       = 1'b1;
        push_block(0);
        repeat (4) step();
        gpio_out[IPID_TRIG] = 1'b0;
        wait_frame("dropmid");
        check("dropmid_err", 32'(frame_err), 32'd1);

        // Reset request during DATA word 7 of block 3
        do_reset();
        pulse(WAKE_REQ);
        for (int b = 0; b < 3; b++) run_block(b, b);
        gpio_out[BLK_MSB:BLK_LSB] = 4'd3;
        gpio_out[IPID_TRIG]       = 1'b1;
        push_words(3, 8);
        cnt     = 0;
        aborted = 1'b0;
        for (int i = 0; i < 30 && !aborted; i++) begin
            step();
            if (gpio_in[IPID_VLD]) cnt++;
            if (cnt == 9) begin
                gpio_out[RST_REQ]   = 1'b1;
                gpio_out[IPID_TRIG] = 1'b0;
                aborted = 1'b1;
            end
        end
        check("abort_reached", 32'(aborted), 32'd1);
        step();
        check("abort_vld", 32'(gpio_in[IPID_VLD]), 32'd0);
        check("abort_data", 32'(gpio_in[31:16]), 32'd0);
        check("abort_addr", 32'(ipid_addr), 32'd0);
        gpio_out[RST_REQ] = 1'b0;
        repeat (10) step();
        check("abort_queue_empty", exp_q.size(), 32'd0);
        pulse(WAKE_REQ);
        run_block(0, 0);

        // Index mismatch and trigger after completion
        do_reset();
        pulse(WAKE_REQ);
        run_block(0, 0);
        run_block(1, 1);
        check("err_clean_before", 32'(frame_err), 32'd0);
        run_block(2, 5);
        check("err_mismatch", 32'(frame_err), 32'd1);
        for (int b = 3; b < 16; b++) run_block(b, b);
        check("err_done", 32'(ipid_done), 32'd1);
        gpio_out[BLK_MSB:BLK_LSB] = 4'd0;
        gpio_out[IPID_TRIG]       = 1'b1;
        vcount = 0;
        repeat (25) begin
            step();
            if (gpio_in[IPID_VLD]) vcount++;
        end
        check("after_done_no_stream", vcount, 32'd0);
        check("after_done_err", 32'(frame_err), 32'd1);
        check("after_done_still_done", 32'(ipid_done), 32'd1);
        gpio_out[IPID_TRIG] = 1'b0;
        step();
        do_reset();
        check("err_cleared_by_rst", 32'(frame_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
